pio_debounce_irq: RTL and testbench

PIO_DEBOUNCE_IRQ -- requirements
Module: pio_debounce_irq

---
 rtl/pio_debounce_irq.sv | 136 +++++++++++++
 tb/tb_pio_debounce_irq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_debounce_irq.sv
// Memory-mapped PIO with per-pin 2-flop synchroniser and debounce, set/clear output
// register and edge-capture interrupt logic.
module pio_debounce_irq #(
  parameter int IN_WIDTH        = 10,
  parameter int OUT_WIDTH       = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_OUT_SET  = 3'd2;
  localparam logic [2:0] A_OUT_CLR  = 3'd3;
  localparam logic [2:0] A_IRQ_MASK = 3'd4;
  localparam logic [2:0] A_EDGE_CAP = 3'd5;
  localparam logic [2:0] A_RISE_EN  = 3'd6;
  localparam logic [2:0] A_FALL_EN  = 3'd7;

  logic [IN_WIDTH-1:0]  sync1_q, sync2_q, deb_q, deb_d;
  logic [IN_WIDTH-1:0]  rise_ev, fall_ev;
  logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
  logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
  logic [31:0]          rdata_q, rdata_d, rd_mux;
  logic [IN_WIDTH-1:0]  wdata_in, w1c;
  logic [OUT_WIDTH-1:0] wdata_out;
  logic                 unused_wdata;

  assign wdata_in     = avs_writedata[IN_WIDTH-1:0];
  assign wdata_out    = avs_writedata[OUT_WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  // Debounce: a channel flips only after sync2 has disagreed with deb for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    deb_d   = deb_q;
    rise_ev = '0;
    fall_ev = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i]   = sync2_q[i];
          rise_ev[i] = sync2_q[i];
          fall_ev[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (avs_write) begin
      case (avs_address)
        A_DATA_OUT: data_out_d = wdata_out;
        A_OUT_SET:  data_out_d = data_out_q | wdata_out;
        A_OUT_CLR:  data_out_d = data_out_q & ~wdata_out;
        A_IRQ_MASK: irq_mask_d = wdata_in;
        A_EDGE_CAP: w1c        = wdata_in;
        A_RISE_EN:  rise_en_d  = wdata_in;
        A_FALL_EN:  fall_en_d  = wdata_in;
        default:    ;
      endcase
    end
    // A capture arriving with a clear of the same bit keeps the bit set.
    edge_cap_d = (edge_cap_q & ~w1c) | (rise_ev & rise_en_q) | (fall_ev & fall_en_q);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = deb_q;
      A_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out_q;
      A_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask_q;
      A_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap_q;
      A_RISE_EN:  rd_mux[IN_WIDTH-1:0]  = rise_en_q;
      A_FALL_EN:  rd_mux[IN_WIDTH-1:0]  = fall_en_q;
      default:    rd_mux = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
      data_out_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      rdata_q    <= '0;
    end else begin
      sync1_q    <= pio_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      rdata_q    <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign pio_out      = data_out_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Bench for pio_debounce_irq: directed scenarios plus random bus/pin traffic,
// scored against a sample-window reference model.
module tb_pio_debounce_irq;

  localparam int IW = 4;
  localparam int OW = 8;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [IW-1:0] pio_in = '0;
  logic [OW-1:0] pio_out;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  pio_debounce_irq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(D)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: deb flips when the last D synchronised samples all disagree with it.
  logic [IW-1:0] m_s1, m_s2, m_deb, m_mask, m_cap, m_rise, m_fall;
  logic [IW-1:0] m_newdeb, m_rev, m_fev, m_w1c;
  logic [OW-1:0] m_out;
  logic [31:0]   m_rdata;
  logic          m_irq;
  bit            m_rd_due;
  logic [IW-1:0] hist[$];
  logic [31:0]   exp_q[$];
  bit            all_diff;

  function automatic logic [31:0] reg_value(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_deb};
      3'd1: return {24'd0, m_out};
      3'd4: return {28'd0, m_mask};
      3'd5: return {28'd0, m_cap};
      3'd6: return {28'd0, m_rise};
      3'd7: return {28'd0, m_fall};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_cap = '0;
      m_rise = '0; m_fall = '0; m_out = '0; m_rdata = '0; m_irq = 1'b0;
      m_rd_due = 1'b0;
      hist.delete();
      exp_q.delete();
    end else begin
      m_rd_due = avs_read;
      if (avs_read) begin
        m_rdata = reg_value(avs_address);
        exp_q.push_back(m_rdata);
      end
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_newdeb = m_deb;
      for (int i = 0; i < IW; i++) begin
        all_diff = (hist.size() == D);
        foreach (hist[k]) if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) m_newdeb[i] = m_s2[i];
      end
      m_rev = m_newdeb & ~m_deb;
      m_fev = ~m_newdeb & m_deb;
      m_w1c = (avs_write && avs_address == 3'd5) ? avs_writedata[IW-1:0] : '0;
      m_cap = (m_cap & ~m_w1c) | (m_rev & m_rise) | (m_fev & m_fall);
      if (avs_write) begin
        case (avs_address)
          3'd1: m_out = avs_writedata[OW-1:0];
          3'd2: m_out = m_out | avs_writedata[OW-1:0];
          3'd3: m_out = m_out & ~avs_writedata[OW-1:0];
          3'd4: m_mask = avs_writedata[IW-1:0];
          3'd6: m_rise = avs_writedata[IW-1:0];
          3'd7: m_fall = avs_writedata[IW-1:0];
          default: ;
        endcase
      end
      m_deb = m_newdeb;
      m_s2  = m_s1;
      m_s1  = pio_in;
      m_irq = |(m_cap & m_mask);
    end
  end

  // Monitor: compares outputs every cycle; read data is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pio_out", 32'(pio_out), 32'(m_out));
      check("irq", 32'(irq), 32'(m_irq));
      if (m_rd_due) begin
        if (exp_q.size() == 0) check("rdata_queue_empty", 32'd1, 32'd0);
        else check("rdata", avs_readdata, exp_q.pop_front());
      end else begin
        check("rdata_hold", avs_readdata, m_rdata);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    avs_read = 1'b1; avs_address = a;
    cyc();
    avs_read = 1'b0;
    check(name, avs_readdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_pio_out", 32'(pio_out), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rdata", avs_readdata, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc();

    // Debounced rise on bit0 with capture and interrupt.
    wr(3'd6, 32'h3);
    wr(3'd4, 32'h1);
    pio_in = 4'b0001;
    cyc(5);
    rd(3'd0, 32'h0, "data_in_edge6_pre");
    rd(3'd0, 32'h1, "data_in_edge7");
    check("irq_after_rise", 32'(irq), 32'd1);

    // 3-cycle glitch on bit1 is rejected.
    pio_in = 4'b0011;
    cyc(3);
    pio_in = 4'b0001;
    cyc(10);
    rd(3'd0, 32'h1, "glitch_data_in");
    rd(3'd5, 32'h1, "glitch_edge_cap");

    wr(3'd5, 32'h1);
    check("irq_after_w1c", 32'(irq), 32'd0);

    // Output register set/clear.
    wr(3'd1, 32'hF0);
    check("out_write", 32'(pio_out), 32'hF0);
    wr(3'd2, 32'h03);
    check("out_set", 32'(pio_out), 32'hF3);
    wr(3'd3, 32'h10);
    check("out_clr", 32'(pio_out), 32'hE3);
    rd(3'd2, 32'h0, "read_out_set");
    rd(3'd3, 32'h0, "read_out_clr");
    rd(3'd1, 32'hE3, "read_data_out");
    wr(3'd0, 32'hF);
    rd(3'd0, 32'h1, "data_in_write_ignored");

    // Captured bit stays hidden until masked in.
    wr(3'd4, 32'h0);
    pio_in = 4'b0000; cyc(10);
    pio_in = 4'b0001; cyc(10);
    check("irq_masked_off", 32'(irq), 32'd0);
    rd(3'd5, 32'h1, "cap_while_masked");
    wr(3'd4, 32'h1);
    check("irq_mask_on", 32'(irq), 32'd1);
    wr(3'd5, 32'hF);

    // Fall capture coinciding with a W1C of the same bit.
    wr(3'd6, 32'h0);
    pio_in = 4'b0011; cyc(10);
    wr(3'd5, 32'hF);
    wr(3'd7, 32'h2);
    pio_in = 4'b0001;
    cyc(5);
    wr(3'd5, 32'h2);
    rd(3'd5, 32'h2, "set_beats_w1c");

    // Asynchronous reset mid-debounce.
    wr(3'd4, 32'h2);
    wr(3'd1, 32'hFF);
    rd(3'd1, 32'hFF, "pre_reset_out");
    pio_in = 4'b0000; cyc(10);
    pio_in = 4'b0001; cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pio_out", 32'(pio_out), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_rdata", avs_readdata, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    wr(3'd6, 32'h1);
    cyc(3);
    rd(3'd0, 32'h0, "post_rst_edge5");
    rd(3'd0, 32'h0, "post_rst_edge6_pre");
    rd(3'd0, 32'h1, "post_rst_edge7");
    rd(3'd5, 32'h1, "post_rst_rise_cap");

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      avs_read      = ($urandom_range(3) == 0);
      avs_write     = ($urandom_range(3) == 0);
      avs_address   = 3'($urandom_range(7));
      avs_writedata = $urandom;
      if ($urandom_range(5) == 0) pio_in[$urandom_range(IW-1)] ^= 1'b1;
      cyc();
    end
    avs_read = 1'b0; avs_write = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
